// File: rtl/tenv_clock_ctrl_if.sv
// Request-side bundle for tenv_clock_ctrl: two reconfiguration requesters,
// each with valid/ready and the requested high/low times.
interface tenv_clock_ctrl_if #(
  parameter int unsigned TIME_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [TIME_W-1:0] req0_high;
  logic [TIME_W-1:0] req0_low;
  logic              req1_valid;
  logic              req1_ready;
  logic [TIME_W-1:0] req1_high;
  logic [TIME_W-1:0] req1_low;

  modport master (
    output req0_valid, req0_high, req0_low,
    output req1_valid, req1_high, req1_low,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_high, req0_low,
    input  req1_valid, req1_high, req1_low,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/tenv_clock_ctrl.sv
// Round-robin reconfiguration sequencer for the testbench clock generator.
// Optional feature: define TENV_CLOCK_CTRL_HALT_EN to add the `halt` input.
module tenv_clock_ctrl #(
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned STOP_CYCLES = 2,
  parameter int unsigned WARMUP      = 4,
  parameter int unsigned DEF_HIGH    = 10,
  parameter int unsigned DEF_LOW     = 10
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TENV_CLOCK_CTRL_HALT_EN
  input  logic              halt,
`endif
  tenv_clock_ctrl_if.slave  req,
  output logic              gen_en,
  output logic              gen_init,
  output logic [TIME_W-1:0] gen_time_high,
  output logic [TIME_W-1:0] gen_time_low,
  output logic              running,
  output logic              grant_id,
  output logic              cfg_err
);

  localparam int unsigned CNT_MAX = (STOP_CYCLES > WARMUP) ? STOP_CYCLES : WARMUP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, STOP, LOAD, INIT, WARM, RUN} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [TIME_W-1:0] pend_high, pend_high_d;
  logic [TIME_W-1:0] pend_low, pend_low_d;
  logic [TIME_W-1:0] time_high_d, time_low_d;
  logic              ptr, ptr_d;
  logic              grant_d, cfg_err_d;
  logic              gen_en_d, gen_init_d, running_d;
  logic              halt_w;
  logic              open, sel1, accept;
  logic [TIME_W-1:0] sel_high, sel_low;

`ifdef TENV_CLOCK_CTRL_HALT_EN
  assign halt_w = halt;
`else
  assign halt_w = 1'b0;
`endif

  // Arbiter: a lone valid wins; on contention the pointer (not-last-grant) wins.
  assign open     = !rst && !halt_w && ((state == IDLE) || (state == RUN));
  assign sel1     = req.req1_valid && (!req.req0_valid || ptr);
  assign req.req0_ready = open && req.req0_valid && !sel1;
  assign req.req1_ready = open && sel1;
  assign accept   = req.req0_ready || req.req1_ready;
  assign sel_high = sel1 ? req.req1_high : req.req0_high;
  assign sel_low  = sel1 ? req.req1_low  : req.req0_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pend_high     <= '0;
      pend_low      <= '0;
      ptr           <= 1'b0;
      grant_id      <= 1'b0;
      cfg_err       <= 1'b0;
      gen_en        <= 1'b0;
      gen_init      <= 1'b0;
      running       <= 1'b0;
      gen_time_high <= TIME_W'(DEF_HIGH);
      gen_time_low  <= TIME_W'(DEF_LOW);
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      pend_high     <= pend_high_d;
      pend_low      <= pend_low_d;
      ptr           <= ptr_d;
      grant_id      <= grant_d;
      cfg_err       <= cfg_err_d;
      gen_en        <= gen_en_d;
      gen_init      <= gen_init_d;
      running       <= running_d;
      gen_time_high <= time_high_d;
      gen_time_low  <= time_low_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pend_high_d = pend_high;
    pend_low_d  = pend_low;
    ptr_d       = ptr;
    grant_d     = grant_id;
    cfg_err_d   = 1'b0;
    time_high_d = gen_time_high;
    time_low_d  = gen_time_low;

    case (state)
      IDLE, RUN: begin
        if (accept) begin
          grant_d     = sel1;
          ptr_d       = !sel1;
          pend_high_d = sel_high;
          pend_low_d  = sel_low;
          // Zero time is rejected: flag it and stay where we are.
          if ((sel_high == '0) || (sel_low == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = STOP;
            cnt_d   = CNT_W'(STOP_CYCLES - 1);
          end
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_d     = LOAD;
          time_high_d = pend_high;
          time_low_d  = pend_low;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      LOAD: state_d = INIT;
      INIT: begin
        state_d = WARM;
        cnt_d   = CNT_W'(WARMUP - 1);
      end
      WARM: begin
        if (cnt == '0) state_d = RUN;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Halt overrides everything outside IDLE; generator times are kept.
    if (halt_w && (state != IDLE)) begin
      state_d     = IDLE;
      cfg_err_d   = 1'b0;
      time_high_d = gen_time_high;
      time_low_d  = gen_time_low;
    end

    gen_en_d   = (state_d == WARM) || (state_d == RUN);
    gen_init_d = (state_d == INIT);
    running_d  = (state_d == RUN);
  end

endmodule
